argmax_classifier: RTL and testbench

//  Consumes the final fully-connected layer's output stream: Beats beats of Lanes scores per image.

---
 rtl/argmax_classifier.sv | 111 +++++++++++
 tb/tb_argmax_classifier.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// Streaming argmax over Beats beats of Lanes scores; reports the winning class behind valid/ready.
// Optional ARGMAX_SCORE_EN adds an out_score port carrying the winning score.
module argmax_classifier #(
    parameter  int BitSize = 8,
    parameter  int Lanes   = 2,
    parameter  int Beats   = 4,
    parameter  int Signed  = 1,
    localparam int ClassW  = (Lanes * Beats > 1) ? $clog2(Lanes * Beats) : 1,
    localparam int BeatW   = (Beats > 1) ? $clog2(Beats) : 1,
    localparam int LaneW   = (Lanes > 1) ? $clog2(Lanes) : 1
) (
    input  logic                            clk,
    input  logic                            res_n,
    input  logic                            in_valid,
    input  logic [Lanes-1:0][BitSize-1:0]   in_data,
    input  logic                            in_done,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [ClassW-1:0]               out_class,
    output logic                            out_err
`ifdef ARGMAX_SCORE_EN
    ,
    output logic [BitSize-1:0]              out_score
`endif
);

    logic [BeatW-1:0]   r_beat_cnt;
    logic [BitSize-1:0] r_run_max;
    logic [ClassW-1:0]  r_run_idx;
    logic               r_valid;
    logic [ClassW-1:0]  r_class;
    logic               r_err;

    logic [BitSize-1:0] w_best_val;
    logic [LaneW-1:0]   w_best_lane;
    logic [ClassW-1:0]  w_cand_idx;
    logic               w_take;
    logic [BitSize-1:0] w_win_val;
    logic [ClassW-1:0]  w_win_idx;
    logic               w_last;
    logic               w_commit;

    // Strict greater-than: ties always keep the earlier (lower) class index.
    function automatic logic gt(input logic [BitSize-1:0] a, input logic [BitSize-1:0] b);
        if (Signed != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    always_comb begin
        w_best_val  = in_data[0];
        w_best_lane = '0;
        for (int l = 1; l < Lanes; l++) begin
            if (gt(in_data[l], w_best_val)) begin
                w_best_val  = in_data[l];
                w_best_lane = LaneW'(l);
            end
        end
    end

    assign w_cand_idx = ClassW'(int'(r_beat_cnt) * Lanes + int'(w_best_lane));
    assign w_take     = (r_beat_cnt == '0) || gt(w_best_val, r_run_max);
    assign w_win_val  = w_take ? w_best_val : r_run_max;
    assign w_win_idx  = w_take ? w_cand_idx : r_run_idx;
    assign w_last     = (r_beat_cnt == BeatW'(Beats - 1));
    assign w_commit   = in_valid && w_last;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_beat_cnt <= '0;
            r_run_max  <= '0;
            r_run_idx  <= '0;
            r_valid    <= 1'b0;
            r_class    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (in_valid) begin
                r_run_max  <= w_win_val;
                r_run_idx  <= w_win_idx;
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
            end
            // A done marker in the middle of a frame drops the partial image.
            if (in_done) begin
                r_beat_cnt <= '0;
                if (r_beat_cnt != '0 && !w_commit) r_err <= 1'b1;
            end
            if (w_commit) begin
                r_valid <= 1'b1;
                r_class <= w_win_idx;
                if (r_valid && !out_ready) r_err <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_class = r_class;
    assign out_err   = r_err;

`ifdef ARGMAX_SCORE_EN
    logic [BitSize-1:0] r_score;

    always_ff @(posedge clk) begin
        if (!res_n)        r_score <= '0;
        else if (w_commit) r_score <= w_win_val;
    end

    assign out_score = r_score;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: signed and unsigned instances share one stimulus stream.
// Build with ARGMAX_SCORE_EN defined to also check out_score.
module tb_argmax_classifier;

    logic            clk = 1'b0;
    logic            res_n;
    logic            in_valid;
    logic [1:0][7:0] in_data;
    logic            in_done;
    logic            out_ready;

    logic       s_valid, u_valid, s_err, u_err;
    logic [2:0] s_class, u_class;
`ifdef ARGMAX_SCORE_EN
    logic [7:0] s_score, u_score;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    argmax_classifier #(.BitSize(8), .Lanes(2), .Beats(4), .Signed(1)) dut_s (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
        .in_done(in_done), .out_ready(out_ready),
        .out_valid(s_valid), .out_class(s_class), .out_err(s_err)
`ifdef ARGMAX_SCORE_EN
        , .out_score(s_score)
`endif
    );

    argmax_classifier #(.BitSize(8), .Lanes(2), .Beats(4), .Signed(0)) dut_u (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
        .in_done(in_done), .out_ready(out_ready),
        .out_valid(u_valid), .out_class(u_class), .out_err(u_err)
`ifdef ARGMAX_SCORE_EN
        , .out_score(u_score)
`endif
    );

    typedef struct {
        logic [7:0][7:0] s;
        int              exp_s;
        int              exp_u;
        logic [7:0]      sc_s;
        logic [7:0]      sc_u;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i,
                           input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                           input logic [7:0] a3, input logic [7:0] a4, input logic [7:0] a5,
                           input logic [7:0] a6, input logic [7:0] a7,
                           input int es, input int eu, input logic [7:0] ss, input logic [7:0] su);
        vecs[i].s[0] = a0; vecs[i].s[1] = a1; vecs[i].s[2] = a2; vecs[i].s[3] = a3;
        vecs[i].s[4] = a4; vecs[i].s[5] = a5; vecs[i].s[6] = a6; vecs[i].s[7] = a7;
        vecs[i].exp_s = es; vecs[i].exp_u = eu;
        vecs[i].sc_s  = ss; vecs[i].sc_u  = su;
    endtask

    // Drives four beats on consecutive cycles; returns at the negedge right after the commit edge.
    task automatic send_image(input logic [7:0][7:0] s, input bit done_last, input bit ready_last);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_data[0] = s[2*b];
            in_data[1] = s[2*b+1];
            if (b == 3) begin
                in_done   = done_last;
                out_ready = ready_last;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_done   = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid   = 1'b1;
        in_data[0] = a;
        in_data[1] = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic accept(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " valid drops after accept"}, {31'd0, s_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res_n = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
    endtask

    logic [7:0][7:0] img;

    initial begin
        res_n = 1'b0; in_valid = 1'b0; in_data = '0; in_done = 1'b0; out_ready = 1'b0;

        set_vec(0, 8'h03, 8'h09, 8'h01, 8'h04, 8'h09, 8'h02, 8'h00, 8'h07, 1, 1, 8'h09, 8'h09);
        set_vec(1, 8'h80, 8'hF0, 8'h90, 8'hA0, 8'hC0, 8'hD0, 8'hFE, 8'h81, 6, 6, 8'hFE, 8'hFE);
        set_vec(2, 8'h05, 8'hFF, 8'h10, 8'h7F, 8'h80, 8'h00, 8'h01, 8'h02, 3, 1, 8'h7F, 8'hFF);
        set_vec(3, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 0, 0, 8'h10, 8'h10);
        set_vec(4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h50, 7, 7, 8'h50, 8'h50);
        set_vec(5, 8'h20, 8'h60, 8'h10, 8'h60, 8'h60, 8'h5F, 8'h00, 8'h00, 1, 1, 8'h60, 8'h60);
        set_vec(6, 8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 8'h7F, 8'h80);

        @(negedge clk);
        @(negedge clk);
        chk("reset valid", {31'd0, s_valid}, 32'd0);
        chk("reset class", {29'd0, s_class}, 32'd0);
        chk("reset err",   {31'd0, s_err},   32'd0);
`ifdef ARGMAX_SCORE_EN
        chk("reset score", {24'd0, s_score}, 32'd0);
`endif
        res_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            send_image(vecs[i].s, 1'b0, 1'b0);
            chk($sformatf("v%0d valid", i), {31'd0, s_valid}, 32'd1);
            chk($sformatf("v%0d class signed", i), {29'd0, s_class}, vecs[i].exp_s);
            chk($sformatf("v%0d class unsigned", i), {29'd0, u_class}, vecs[i].exp_u);
            chk($sformatf("v%0d err", i), {30'd0, s_err, u_err}, 32'd0);
`ifdef ARGMAX_SCORE_EN
            chk($sformatf("v%0d score signed", i), {24'd0, s_score}, {24'd0, vecs[i].sc_s});
            chk($sformatf("v%0d score unsigned", i), {24'd0, u_score}, {24'd0, vecs[i].sc_u});
`endif
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("v%0d hold valid", i), {31'd0, s_valid}, 32'd1);
            chk($sformatf("v%0d hold class", i), {29'd0, s_class}, vecs[i].exp_s);
            accept($sformatf("v%0d", i));
        end

        // Accept of image 1 coincides with commit of image 2.
        send_image(vecs[0].s, 1'b0, 1'b0);
        send_image(vecs[2].s, 1'b0, 1'b1);
        chk("t4 valid", {31'd0, s_valid}, 32'd1);
        chk("t4 class", {29'd0, s_class}, 32'd3);
        chk("t4 err",   {31'd0, s_err},   32'd0);
        accept("t4");

        // Overrun: second image lands while the first is still unaccepted.
        send_image(vecs[0].s, 1'b0, 1'b0);
        img = '0;
        img[5] = 8'h40;
        send_image(img, 1'b0, 1'b0);
        chk("t3 valid", {31'd0, s_valid}, 32'd1);
        chk("t3 class", {29'd0, s_class}, 32'd5);
        chk("t3 err",   {31'd0, s_err},   32'd1);
        accept("t3");
        do_reset();
        chk("t3 err cleared by reset", {31'd0, s_err}, 32'd0);

        // Short frame terminated by in_done.
        send_beat(8'h7F, 8'h7F);
        send_beat(8'h7F, 8'h7F);
        @(negedge clk);
        in_done = 1'b1;
        @(negedge clk);
        in_done = 1'b0;
        chk("t5 no valid", {31'd0, s_valid}, 32'd0);
        chk("t5 err",      {31'd0, s_err},   32'd1);
        send_image(vecs[0].s, 1'b0, 1'b0);
        chk("t5 next class", {29'd0, s_class}, 32'd1);
        chk("t5 err sticky", {31'd0, s_err},   32'd1);
        accept("t5");

        // Reset in mid-image discards the partial frame.
        do_reset();
        send_beat(8'h7F, 8'h7F);
        send_beat(8'h7F, 8'h7F);
        @(negedge clk);
        res_n = 1'b0;
        @(negedge clk);
        chk("t6 reset valid", {31'd0, s_valid}, 32'd0);
        chk("t6 reset class", {29'd0, s_class}, 32'd0);
        chk("t6 reset err",   {31'd0, s_err},   32'd0);
        res_n = 1'b1;
        send_image(vecs[4].s, 1'b0, 1'b0);
        chk("t6 class", {29'd0, s_class}, 32'd7);
`ifdef ARGMAX_SCORE_EN
        chk("t6 score", {24'd0, s_score}, 32'h50);
`endif
        accept("t6");

        // in_done on the final beat commits normally.
        send_image(vecs[2].s, 1'b1, 1'b0);
        chk("done-last valid", {31'd0, s_valid}, 32'd1);
        chk("done-last class", {29'd0, s_class}, 32'd3);
        chk("done-last err",   {31'd0, s_err},   32'd0);
        accept("done-last");
        send_image(vecs[0].s, 1'b0, 1'b0);
        chk("after done-last class", {29'd0, s_class}, 32'd1);
        chk("after done-last err",   {31'd0, s_err},   32'd0);
        accept("after done-last");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
